// File: rtl/key_step_ctrl_pkg.sv
// Shared board-level types and constants for the input conditioning path.
package gb_board_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HELD
  } step_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  localparam int unsigned KEY_RST  = 0;
  localparam int unsigned KEY_STEP = 1;

endpackage

// File: rtl/key_step_ctrl_if.sv
// Board-side bundle for key_step_ctrl: raw inputs in, conditioned controls out.
interface key_step_ctrl_if #(
  parameter int unsigned COUNT_W = 16
);

  logic [1:0]         i_key_n;
  logic               i_sw_step;
  logic               o_clk_en;
  logic               o_step_pulse;
  logic               o_rst_req;
  logic [COUNT_W-1:0] o_step_count;

  modport slave (
    input  i_key_n,
    input  i_sw_step,
    output o_clk_en,
    output o_step_pulse,
    output o_rst_req,
    output o_step_count
  );

  modport master (
    output i_key_n,
    output i_sw_step,
    input  o_clk_en,
    input  o_step_pulse,
    input  o_rst_req,
    input  o_step_count
  );

endinterface

// File: rtl/key_step_ctrl_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low key.
module key_debounce
  import gb_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Idle level is 1 (released) for every active-low key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_stable;

endmodule

// File: rtl/key_step_ctrl.sv
// Conditions raw buttons/mode switch into a datapath clock enable, step pulse,
// reset request and wrapping step counter.
module key_step_ctrl
  import gb_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  key_step_ctrl_if.slave  bus
);

  logic [1:0]         w_key_lvl;
  logic               r_sw_meta;
  logic               r_sw_sync;
  logic               w_step_mode;
  logic               w_step_press;
  logic               w_rst_req;

  step_state_t        r_state;
  step_state_t        w_next;

  logic               w_fire;
  logic               w_clk_en_d;
  logic [COUNT_W-1:0] w_count_d;

  logic               r_clk_en;
  logic               r_step_pulse;
  logic [COUNT_W-1:0] r_count;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (bus.i_key_n[KEY_RST]),
    .o_level(w_key_lvl[KEY_RST])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (bus.i_key_n[KEY_STEP]),
    .o_level(w_key_lvl[KEY_STEP])
  );

  // Mode switch is level-only: synchronized but deliberately not debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
    end else begin
      r_sw_meta <= bus.i_sw_step;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_step_mode  = r_sw_sync;
  assign w_step_press = ~w_key_lvl[KEY_STEP];
  assign w_rst_req    = ~w_key_lvl[KEY_RST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A press accepted in run mode parks in HELD, so it can never fire later.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_step_press) w_next = w_step_mode ? FIRE : HELD;
      FIRE:    w_next = HELD;
      HELD:    if (!w_step_press) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_fire     = (w_next == FIRE);
    w_clk_en_d = ~w_step_mode | w_fire;
    w_count_d  = r_count;
    if (w_rst_req)   w_count_d = '0;
    else if (w_fire) w_count_d = r_count + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_en     <= 1'b0;
      r_step_pulse <= 1'b0;
      r_count      <= '0;
    end else begin
      r_clk_en     <= w_clk_en_d;
      r_step_pulse <= w_fire;
      r_count      <= w_count_d;
    end
  end

  assign bus.o_clk_en     = r_clk_en;
  assign bus.o_step_pulse = r_step_pulse;
  assign bus.o_rst_req    = w_rst_req;
  assign bus.o_step_count = r_count;

endmodule
